// File: rtl/rand_sum_seq_ctrl.sv
// Sequencer for the rand -> div -> sum_3 datapath: each step edge runs three
// rand/divide samples into x/y/z and then forms sum_val. Optional macro AUTO_RUN_EN.
module rand_sum_seq_ctrl #(
  parameter int RW      = 8,
  parameter int QW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          CLOCK_50,
  input  logic          rst,
  input  logic          step,
  input  logic [RW-1:0] rand_num,
  output logic          rand_en,
  output logic          div_start,
  output logic [RW-1:0] div_opnd,
  input  logic          div_done,
  input  logic [QW-1:0] div_quot,
  output logic [QW-1:0] x,
  output logic [QW-1:0] y,
  output logic [QW-1:0] z,
  output logic [QW+1:0] sum_val,
  output logic          sum_valid,
  output logic          busy,
  output logic          err,
  output logic [2:0]    state_dbg
);

  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_DSTART = 3'd2,
    S_DWAIT  = 3'd3,
    S_STORE  = 3'd4,
    S_SUM    = 3'd5
  } state_t;

  state_t        state;
  logic          step_q;
  logic [1:0]    idx;
  logic [CW-1:0] wait_cnt;
  logic [QW-1:0] quot_lat;
  logic          go;
  logic          start_run;

  function automatic logic [QW+1:0] sum3(input logic [QW-1:0] a,
                                         input logic [QW-1:0] b,
                                         input logic [QW-1:0] c);
    return {2'b00, a} + {2'b00, b} + {2'b00, c};
  endfunction

  assign go = step & ~step_q;

`ifdef AUTO_RUN_EN
  // Set once the first run completes; from then on IDLE relaunches by itself.
  logic auto_q;
  assign start_run = go | auto_q;
`else
  assign start_run = go;
`endif

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state     <= S_IDLE;
      step_q    <= 1'b0;
      idx       <= 2'd0;
      wait_cnt  <= '0;
      quot_lat  <= '0;
      rand_en   <= 1'b0;
      div_start <= 1'b0;
      div_opnd  <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      sum_val   <= '0;
      sum_valid <= 1'b0;
      err       <= 1'b0;
`ifdef AUTO_RUN_EN
      auto_q    <= 1'b0;
`endif
    end else begin
      step_q    <= step;
      rand_en   <= 1'b0;
      div_start <= 1'b0;
      sum_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_run) begin
            state   <= S_SAMPLE;
            idx     <= 2'd0;
            rand_en <= 1'b1;
          end
        end
        S_SAMPLE: begin
          state     <= S_DSTART;
          div_start <= 1'b1;
        end
        S_DSTART: begin
          div_opnd <= rand_num;
          wait_cnt <= '0;
          state    <= S_DWAIT;
        end
        S_DWAIT: begin
          // done takes priority over a timeout landing in the same cycle
          if (div_done) begin
            quot_lat <= div_quot;
            state    <= S_STORE;
          end else if (wait_cnt == TO_LAST) begin
            quot_lat <= '0;
            err      <= 1'b1;
            state    <= S_STORE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_STORE: begin
          case (idx)
            2'd0:    x <= quot_lat;
            2'd1:    y <= quot_lat;
            default: z <= quot_lat;
          endcase
          if (idx == 2'd2) begin
            state <= S_SUM;
          end else begin
            idx     <= idx + 2'd1;
            state   <= S_SAMPLE;
            rand_en <= 1'b1;
          end
        end
        S_SUM: begin
          sum_val   <= sum3(x, y, z);
          sum_valid <= 1'b1;
          state     <= S_IDLE;
`ifdef AUTO_RUN_EN
          auto_q    <= 1'b1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_sum_seq_ctrl.sv
// Self-checking bench for rand_sum_seq_ctrl: divider/LFSR stubs plus a schedule-based
// reference model compared against every output on every cycle.
module tb_rand_sum_seq_ctrl;

  localparam int RW      = 8;
  localparam int QW      = 8;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          step;
  logic [RW-1:0] rand_num = 8'h5A;
  logic          rand_en;
  logic          div_start;
  logic [RW-1:0] div_opnd;
  logic          div_done = 1'b0;
  logic [QW-1:0] div_quot = '0;
  logic [QW-1:0] x, y, z;
  logic [QW+1:0] sum_val;
  logic          sum_valid;
  logic          busy;
  logic          err;
  logic [2:0]    state_dbg;

  rand_sum_seq_ctrl #(.RW(RW), .QW(QW), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .step     (step),
    .rand_num (rand_num),
    .rand_en  (rand_en),
    .div_start(div_start),
    .div_opnd (div_opnd),
    .div_done (div_done),
    .div_quot (div_quot),
    .x        (x),
    .y        (y),
    .z        (z),
    .sum_val  (sum_val),
    .sum_valid(sum_valid),
    .busy     (busy),
    .err      (err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Divider stub configuration for the next run: latency 0 means never done.
  int unsigned cfg_lat[3];
  logic [7:0]  cfg_val[3];

  int unsigned st_i = 0, st_req = 0, st_ack = 0, st_lat = 0;
  logic [7:0]  st_val = '0;
  int unsigned adv_req = 0, adv_ack = 0;
  int unsigned sb_cnt = 0;
  bit          sb_act = 0;
  logic [7:0]  sb_val = '0;

  always @(negedge clk) begin
    if (rst) st_i = 0;
    else if (div_start) begin
      st_lat = cfg_lat[st_i];
      st_val = cfg_val[st_i];
      st_req++;
      st_i = (st_i == 2) ? 0 : st_i + 1;
    end
    if (rand_en) adv_req++;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    div_done = 1'b0;
    div_quot = 8'($urandom_range(0, 255));
    if (st_ack != st_req) begin
      st_ack = st_req;
      sb_cnt = st_lat;
      sb_val = st_val;
      sb_act = (st_lat != 0);
    end
    if (sb_act) begin
      sb_cnt--;
      if (sb_cnt == 0) begin
        div_done = 1'b1;
        div_quot = sb_val;
        sb_act   = 0;
      end
    end
    if (adv_ack != adv_req) begin
      adv_ack  = adv_req;
      rand_num = 8'($urandom_range(0, 255));
    end
  end

  // Reference model: on an accepted go the whole run is laid out as a schedule.
  bit          m_run = 0, chk_en = 0, rst_prev = 0, step_prev = 0;
  int unsigned m_a[3], m_e[3], m_sumc = 0, m_svc = 0;
  logic [7:0]  m_q[3];
  bit          m_to[3];
  logic [7:0]  ex = 0, ey = 0, ez = 0, eop = 0;
  logic [9:0]  es = 0;
  logic        eerr = 0;
  int unsigned go_cyc = 0, sv_cyc = 0, sv_count = 0;

  always @(negedge clk) begin
    int unsigned c;
    logic [2:0]  est;
    logic        ere, eds, ebusy, esv;
    c = cyc;
    if (rst_prev) begin
      chk_en = 1; m_run = 0;
      ex = 0; ey = 0; ez = 0; es = 0; eerr = 0; eop = 0;
    end
    ere = 0; eds = 0; ebusy = 0; esv = 0; est = 3'd0;
    if (m_run) begin
      for (int k = 0; k < 3; k++) begin
        if (c == m_a[k]) begin ere = 1; est = 3'd1; end
        if (c == m_a[k] + 1) begin eds = 1; est = 3'd2; end
        if (c >= m_a[k] + 2 && c <= m_a[k] + m_e[k] + 1) est = 3'd3;
        if (c == m_a[k] + m_e[k] + 2) begin
          est = 3'd4;
          if (m_to[k]) eerr = 1;
        end
        if (c == m_a[k] + 2) eop = rand_num;
      end
      if (c == m_a[1]) ex = m_q[0];
      if (c == m_a[2]) ey = m_q[1];
      if (c == m_sumc) begin ez = m_q[2]; est = 3'd5; end
      if (c == m_svc) begin
        esv = 1;
        es  = 10'(m_q[0]) + 10'(m_q[1]) + 10'(m_q[2]);
      end
      ebusy = (c >= m_a[0]) && (c < m_svc);
    end
    if (sum_valid) begin sv_count++; sv_cyc = c; end
    if (chk_en) begin
      chk("busy", busy, ebusy);
      chk("sum_valid", sum_valid, esv);
      chk("rand_en", rand_en, ere);
      chk("div_start", div_start, eds);
      chk("state_dbg", state_dbg, est);
      chk("x", x, ex);
      chk("y", y, ey);
      chk("z", z, ez);
      chk("sum_val", sum_val, es);
      chk("err", err, eerr);
      chk("div_opnd", div_opnd, eop);
    end
    if (chk_en && !rst && step && !step_prev && (!m_run || c >= m_svc)) begin
      m_run  = 1;
      go_cyc = c;
      for (int k = 0; k < 3; k++) begin
        m_to[k] = (cfg_lat[k] == 0) || (cfg_lat[k] > TIMEOUT);
        m_e[k]  = m_to[k] ? TIMEOUT : cfg_lat[k];
        m_q[k]  = m_to[k] ? 8'd0 : cfg_val[k];
      end
      m_a[0] = c + 1;
      m_a[1] = m_a[0] + m_e[0] + 3;
      m_a[2] = m_a[1] + m_e[1] + 3;
      m_sumc = m_a[2] + m_e[2] + 3;
      m_svc  = m_sumc + 1;
    end
    rst_prev  = rst;
    step_prev = rst ? 1'b0 : step;
  end

  task automatic set_cfg(input int unsigned l0, l1, l2, input logic [7:0] v0, v1, v2);
    cfg_lat[0] = l0; cfg_lat[1] = l1; cfg_lat[2] = l2;
    cfg_val[0] = v0; cfg_val[1] = v1; cfg_val[2] = v2;
  endtask

  task automatic pulse(input int len);
    step = 1'b1;
    repeat (len) @(posedge clk);
    #1 step = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!(m_run && cyc > m_svc) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("run_completes_in_budget", (g < 3000), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned svc0;
    rst  = 1'b1;
    step = 1'b0;
    set_cfg(5, 5, 5, 10, 20, 30);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_state", state_dbg, 0);
    chk("reset_sum", sum_val, 0);
    chk("reset_err", err, 0);
    chk("reset_pulses", {rand_en, div_start, sum_valid}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic triple, L=5
    svc0 = sv_count;
    pulse(1);
    wait_done();
    chk("t2_x", x, 10);
    chk("t2_y", y, 20);
    chk("t2_z", z, 30);
    chk("t2_sum", sum_val, 60);
    chk("t2_latency", sv_cyc - go_cyc, 26);
    chk("t2_one_pulse", sv_count - svc0, 1);

    // Maximum quotients
    set_cfg(3, 7, 2, 255, 255, 255);
    pulse(1);
    wait_done();
    chk("t3_sum765", sum_val, 765);
    chk("t3_err", err, 0);

    // Random runs
    for (int r = 0; r < 6; r++) begin
      set_cfg($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      pulse($urandom_range(1, 4));
      wait_done();
    end

    // done in the last allowed DWAIT cycle wins over the timeout
    set_cfg(TIMEOUT, TIMEOUT, TIMEOUT, 1, 2, 3);
    pulse(1);
    wait_done();
    chk("edge_done_wins_err", err, 0);
    chk("edge_done_wins_sum", sum_val, 6);

    // step held high: one run only
    set_cfg(5, 5, 5, 4, 5, 6);
    svc0 = sv_count;
    step = 1'b1;
    repeat (200) @(posedge clk);
    #1 step = 1'b0;
    chk("t5_held_one_run", sv_count - svc0, 1);
    chk("t5_held_sum", sum_val, 15);

    // second edge while busy is dropped
    set_cfg(8, 8, 8, 7, 8, 9);
    svc0 = sv_count;
    pulse(1);
    repeat (4) @(posedge clk);
    #1;
    pulse(1);
    wait_done();
    repeat (40) @(posedge clk);
    #1;
    chk("t5_busy_edge_dropped", sv_count - svc0, 1);

    // divider never answers
    set_cfg(0, 0, 0, 1, 1, 1);
    pulse(1);
    wait_done();
    chk("t4_err", err, 1);
    chk("t4_x", x, 0);
    chk("t4_y", y, 0);
    chk("t4_z", z, 0);
    chk("t4_sum", sum_val, 0);

    // late done (one past timeout) mixed with normal samples
    set_cfg(4, TIMEOUT + 1, 6, 50, 60, 70);
    pulse(1);
    wait_done();
    chk("late_done_y_zero", y, 0);
    chk("late_done_sum", sum_val, 120);

    // reset during DWAIT of the first sample
    set_cfg(20, 20, 20, 11, 12, 13);
    pulse(1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_x", x, 0);
    chk("t6_err", err, 0);
    chk("t6_sum", sum_val, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("t6_late_done_ignored_busy", busy, 0);
    chk("t6_late_done_ignored_x", x, 0);

    // normal run after reset
    set_cfg(2, 3, 4, 100, 101, 102);
    pulse(1);
    wait_done();
    chk("post_reset_sum", sum_val, 303);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
